// File: rtl/cfu_pkg.sv
// Shared types and constants for the CFU command initiator: FSM states,
// function_id field layout and the opcode / funct7 encodings.
package cfu_pkg;

    localparam int FUNC_ID_W  = 10;
    localparam int DATA_W     = 32;
    localparam int REQ_W      = FUNC_ID_W + 2 * DATA_W;

    // function_id = {funct7, opcode}
    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_W   = 3;
    localparam int FUNCT7_LSB = 3;
    localparam int FUNCT7_W   = 7;

    localparam logic [FUNCT7_W-1:0] F7_LOAD_A  = 7'd0;
    localparam logic [FUNCT7_W-1:0] F7_LOAD_B  = 7'd1;
    localparam logic [FUNCT7_W-1:0] F7_LOAD_C  = 7'd2;
    localparam logic [FUNCT7_W-1:0] F7_STORE_A = 7'd3;
    localparam logic [FUNCT7_W-1:0] F7_STORE_B = 7'd4;
    localparam logic [FUNCT7_W-1:0] F7_STORE_C = 7'd5;

    localparam logic [OPCODE_W-1:0] OP_LDST    = 3'd0;
    localparam logic [OPCODE_W-1:0] OP_MATMUL  = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_DELIVER  = 2'd3
    } cfu_state_e;

    // One queued request, packed in the same order as it travels on the bus.
    typedef struct packed {
        logic [FUNC_ID_W-1:0] function_id;
        logic [DATA_W-1:0]    inputs_0;
        logic [DATA_W-1:0]    inputs_1;
    } cfu_req_t;

    function automatic logic [OPCODE_W-1:0] get_opcode(input logic [FUNC_ID_W-1:0] fid);
        return fid[OPCODE_LSB +: OPCODE_W];
    endfunction

    function automatic logic [FUNCT7_W-1:0] get_funct7(input logic [FUNC_ID_W-1:0] fid);
        return fid[FUNCT7_LSB +: FUNCT7_W];
    endfunction

endpackage

// File: rtl/cfu_req_fifo.sv
// Synchronous request FIFO. Full/empty come from a registered occupancy
// count; the head entry is always presented on o_head.
module cfu_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 74
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rd_ptr];

    // Storage write; left unreset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally (power-of-two depth); count holds on push+pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/cfu_cmd_initiator.sv
// Host-to-CFU command initiator: queues host requests, issues one command
// at a time to the CFU, waits for its response (with a timeout) and hands
// the result back to the host in request order.
module cfu_cmd_initiator
    import cfu_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [FUNC_ID_W-1:0] req_function_id,
    input  logic [DATA_W-1:0]    req_inputs_0,
    input  logic [DATA_W-1:0]    req_inputs_1,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [FUNC_ID_W-1:0] cmd_payload_function_id,
    output logic [DATA_W-1:0]    cmd_payload_inputs_0,
    output logic [DATA_W-1:0]    cmd_payload_inputs_1,
    input  logic                 rsp_valid,
    output logic                 rsp_ready,
    input  logic [DATA_W-1:0]    rsp_payload_outputs_0,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [DATA_W-1:0]    res_data,
    output logic                 res_timeout,
    output logic                 busy,
    output logic [7:0]           stale_count
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    cfu_state_e        r_state;
    cfu_state_e        w_state_next;
    cfu_req_t          r_cmd;
    cfu_req_t          w_push_req;
    cfu_req_t          w_head;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_push;
    logic              w_pop;
    logic [TO_W-1:0]   r_to_cnt;
    logic              w_to_expired;
    logic              w_stale;
    logic [DATA_W-1:0] r_res_data;
    logic              r_res_timeout;
    logic [7:0]        r_stale_count;

    // Readiness comes only from the registered count: a full queue refuses
    // even in a cycle where the FSM pops.
    assign req_ready    = !w_fifo_full;
    assign w_push       = req_valid && !w_fifo_full;
    assign w_push_req   = {req_function_id, req_inputs_0, req_inputs_1};
    assign w_to_expired = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign w_stale      = (r_state == ST_IDLE) && rsp_valid;

    cfu_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REQ_W)
    ) u_req_fifo (
        .clk         (clk),
        .rst         (reset),
        .i_push      (w_push),
        .i_push_data (w_push_req),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and per-state handshake outputs.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        cmd_valid    = 1'b0;
        rsp_ready    = 1'b0;
        res_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Accept (and drop) anything the CFU sends while idle.
                rsp_ready = 1'b1;
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cmd_valid = 1'b1;
                if (cmd_ready) begin
                    w_state_next = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                rsp_ready = 1'b1;
                if (rsp_valid || w_to_expired) begin
                    w_state_next = ST_DELIVER;
                end
            end
            ST_DELIVER: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Command payload register, loaded from the queue head on pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cmd <= '0;
        end else if (w_pop) begin
            r_cmd <= w_head;
        end
    end

    // Response wait counter: cleared as the command is accepted, then counts
    // each WAIT_RSP cycle that passes without a response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_to_cnt <= '0;
        end else if (r_state == ST_ISSUE && cmd_ready) begin
            r_to_cnt <= '0;
        end else if (r_state == ST_WAIT_RSP && !rsp_valid && !w_to_expired) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    // Result capture; a response on the last allowed cycle beats the timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_res_data    <= '0;
            r_res_timeout <= 1'b0;
        end else if (r_state == ST_WAIT_RSP) begin
            if (rsp_valid) begin
                r_res_data    <= rsp_payload_outputs_0;
                r_res_timeout <= 1'b0;
            end else if (w_to_expired) begin
                r_res_data    <= '0;
                r_res_timeout <= 1'b1;
            end
        end
    end

    // Saturating count of responses that arrived with nothing outstanding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stale_count <= '0;
        end else if (w_stale && r_stale_count != 8'hFF) begin
            r_stale_count <= r_stale_count + 8'd1;
        end
    end

    assign cmd_payload_function_id = r_cmd.function_id;
    assign cmd_payload_inputs_0    = r_cmd.inputs_0;
    assign cmd_payload_inputs_1    = r_cmd.inputs_1;
    assign res_data                = r_res_data;
    assign res_timeout             = r_res_timeout;
    assign stale_count             = r_stale_count;
    assign busy                    = (r_state != ST_IDLE) || !w_fifo_empty;

endmodule

// File: tb/tb_cfu_cmd_initiator.sv
// Bench for cfu_cmd_initiator: a host driver, a behavioural CFU model and an
// in-order result scoreboard, exercised with directed and random traffic.
module tb_cfu_cmd_initiator;
    import cfu_pkg::*;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [9:0]  req_function_id;
    logic [31:0] req_inputs_0;
    logic [31:0] req_inputs_1;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_payload_function_id;
    logic [31:0] cmd_payload_inputs_0;
    logic [31:0] cmd_payload_inputs_1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_payload_outputs_0;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_timeout;
    logic        busy;
    logic [7:0]  stale_count;

    cfu_cmd_initiator #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .req_valid               (req_valid),
        .req_ready               (req_ready),
        .req_function_id         (req_function_id),
        .req_inputs_0            (req_inputs_0),
        .req_inputs_1            (req_inputs_1),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_payload_function_id (cmd_payload_function_id),
        .cmd_payload_inputs_0    (cmd_payload_inputs_0),
        .cmd_payload_inputs_1    (cmd_payload_inputs_1),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_payload_outputs_0   (rsp_payload_outputs_0),
        .res_valid               (res_valid),
        .res_ready               (res_ready),
        .res_data                (res_data),
        .res_timeout             (res_timeout),
        .busy                    (busy),
        .stale_count             (stale_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Checking bookkeeping
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Model state
    logic [73:0] host_q[$];
    logic [73:0] cmd_q[$];
    logic [32:0] sb_q[$];          // {timeout, data}
    int          acc_cyc_q[$];
    int          res_hs_cyc_q[$];
    int          cr_mode, rr_mode; // 0: always ready, 1: never, 2: random
    int          rsp_delay;        // <0: random 0..5
    bit          host_rand;
    bit          rsp_pending, rsp_is_stale;
    int          rsp_cnt;
    logic [31:0] rsp_data;
    int          exp_stale;
    int          cmd_rise_cyc, cmd_hs_cyc, rsp_hs_cyc, res_rise_cyc;
    int          res_valid_seen, n_res;
    bit          prev_stall, prev_res_stall, prev_cmd_valid, prev_res_valid;
    logic [73:0] prev_cmd;
    logic [32:0] prev_res;

    // Behaviour of the CFU as seen by the host: MATMUL never answers (so the
    // host sees a timeout), loads return inputs_1, stores return 0, any other
    // opcode returns inputs_0 ^ inputs_1.
    function automatic logic [32:0] exp_res(input logic [73:0] r);
        logic [9:0]  fid;
        logic [31:0] a, b;
        fid = r[73:64];
        a   = r[63:32];
        b   = r[31:0];
        if (get_opcode(fid) == OP_MATMUL) return {1'b1, 32'd0};
        if (get_opcode(fid) == OP_LDST) begin
            if (get_funct7(fid) <= F7_LOAD_C) return {1'b0, b};
            return 33'd0;
        end
        return {1'b0, a ^ b};
    endfunction

    task automatic send(input logic [9:0] fid, input logic [31:0] a, input logic [31:0] b);
        host_q.push_back({fid, a, b});
    endtask

    task automatic drive();
        if (host_q.size() > 0) begin
            {req_function_id, req_inputs_0, req_inputs_1} = host_q[0];
            req_valid = !host_rand || ($urandom_range(0, 3) != 0);
        end else begin
            req_valid = 1'b0;
        end
        cmd_ready = (cr_mode == 0) ? 1'b1 : (cr_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        res_ready = (rr_mode == 0) ? 1'b1 : (rr_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        if (rsp_pending) begin
            if (rsp_cnt == 0) rsp_valid = 1'b1;
            else begin
                rsp_cnt--;
                rsp_valid = 1'b0;
            end
        end else begin
            rsp_valid = 1'b0;
        end
        rsp_payload_outputs_0 = rsp_data;
    endtask

    // One clock: observe handshakes mid-cycle, then drive the next cycle.
    task automatic step();
        logic [73:0] cur, e;
        logic [32:0] er;
        @(negedge clk);
        if (rsp_valid && rsp_ready) begin
            rsp_hs_cyc  = cyc;
            rsp_pending = 1'b0;
            if (rsp_is_stale && exp_stale < 255) exp_stale++;
        end
        if (req_valid && req_ready) begin
            cur = {req_function_id, req_inputs_0, req_inputs_1};
            sb_q.push_back(exp_res(cur));
            cmd_q.push_back(cur);
            acc_cyc_q.push_back(cyc);
            void'(host_q.pop_front());
        end
        cur = {cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1};
        if (cmd_valid && !prev_cmd_valid) cmd_rise_cyc = cyc;
        if (prev_stall) chk("cmd_stable", cur, prev_cmd);
        if (cmd_valid && cmd_ready) begin
            cmd_hs_cyc = cyc;
            if (cmd_q.size() == 0) chk("cmd_unexpected", cmd_valid, 0);
            else begin
                e = cmd_q.pop_front();
                chk("cmd_payload", cur, e);
                er = exp_res(e);
                if (!er[32]) begin
                    rsp_pending  = 1'b1;
                    rsp_is_stale = 1'b0;
                    rsp_data     = er[31:0];
                    rsp_cnt      = (rsp_delay < 0) ? int'($urandom_range(0, 5)) : rsp_delay;
                end
            end
        end
        prev_stall     = cmd_valid && !cmd_ready;
        prev_cmd       = cur;
        prev_cmd_valid = cmd_valid;
        if (res_valid && !prev_res_valid) res_rise_cyc = cyc;
        if (res_valid) res_valid_seen++;
        if (prev_res_stall) chk("res_stable", {res_timeout, res_data}, prev_res);
        if (res_valid && res_ready) begin
            res_hs_cyc_q.push_back(cyc);
            $display("res %0d @%0d: data=%h timeout=%0b", n_res, cyc, res_data, res_timeout);
            n_res++;
            if (sb_q.size() == 0) chk("res_unexpected", res_valid, 0);
            else begin
                er = sb_q.pop_front();
                chk("res_data", res_data, er[31:0]);
                chk("res_timeout", res_timeout, er[32]);
            end
        end
        prev_res_stall = res_valid && !res_ready;
        prev_res       = {res_timeout, res_data};
        prev_res_valid = res_valid;
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        bit done;
        k = 0;
        done = 1'b0;
        while (!done && k < budget) begin
            step();
            k++;
            done = (host_q.size() == 0) && (sb_q.size() == 0) && !rsp_pending && !busy;
        end
        chk(tag, done, 1);
    endtask

    task automatic inject_stale(input logic [31:0] d);
        rsp_pending  = 1'b1;
        rsp_is_stale = 1'b1;
        rsp_cnt      = 0;
        rsp_data     = d;
        wait_idle("stale_drain", 20);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_cmd_valid"}, cmd_valid, 0);
        chk({tag, "_cmd_payload"}, {cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1}, 0);
        chk({tag, "_rsp_ready"}, rsp_ready, 1);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_res_timeout"}, res_timeout, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_stale_count"}, stale_count, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [9:0] fid;
        int sel;
        reset = 1'b1;
        req_valid = 1'b0; req_function_id = '0; req_inputs_0 = '0; req_inputs_1 = '0;
        cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_payload_outputs_0 = '0; res_ready = 1'b0;
        cr_mode = 0; rr_mode = 0; rsp_delay = 2; host_rand = 1'b0;
        rsp_pending = 1'b0; rsp_is_stale = 1'b0; rsp_cnt = 0; rsp_data = '0; exp_stale = 0;
        prev_stall = 1'b0; prev_res_stall = 1'b0; prev_cmd_valid = 1'b0; prev_res_valid = 1'b0;
        res_valid_seen = 0; n_res = 0;
        repeat (3) @(posedge clk);
        #1;
        drive();
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk);
        #1;
        drive();

        // Single store: command two cycles after acceptance, result 0.
        acc_cyc_q.delete();
        send({F7_STORE_A, OP_LDST}, 32'd5, 32'hDEADBEEF);
        wait_idle("store_done", 100);
        chk("store_cmd_latency", cmd_rise_cyc - (acc_cyc_q.size() > 0 ? acc_cyc_q[0] : -100), 2);
        chk("store_res_latency", res_rise_cyc - rsp_hs_cyc, 1);

        // Load C returns the CFU data.
        send({F7_LOAD_C, OP_LDST}, 32'd6, 32'h12345678);
        wait_idle("loadc_done", 100);

        // Queue fills while a result is held in DELIVER and the CFU stalls.
        rr_mode = 1;
        send({F7_LOAD_A, OP_LDST}, 32'd1, 32'hA0A0_0000);
        k = 0;
        while (!res_valid && k < 50) begin step(); k++; end
        chk("hold_res_valid", res_valid, 1);
        cr_mode = 1;
        acc_cyc_q.delete();
        for (int i = 0; i < 5; i++) send({F7_LOAD_B, OP_LDST}, 32'(i), 32'h1000 + 32'(i));
        repeat (12) step();
        chk("full_accepts", acc_cyc_q.size(), 4);
        chk("full_req_ready", req_ready, 0);
        chk("full_held", host_q.size(), 1);
        chk("full_busy", busy, 1);
        acc_cyc_q.delete();
        res_hs_cyc_q.delete();
        cr_mode = 0;
        rr_mode = 0;
        wait_idle("full_drain", 300);
        chk("full_pop_refuse",
            (acc_cyc_q.size() > 0 && res_hs_cyc_q.size() > 0) ? acc_cyc_q[0] - res_hs_cyc_q[0] : -1, 2);

        // MATMUL is never answered: timeout after 16 WAIT_RSP cycles.
        send({7'd0, OP_MATMUL}, 32'd1, 32'd2);
        wait_idle("timeout_done", 100);
        chk("timeout_latency", res_rise_cyc - cmd_hs_cyc, 17);

        // Late response while idle is swallowed and counted; traffic continues.
        inject_stale(32'h5A5A5A5A);
        chk("stale_one", stale_count, exp_stale);
        send({F7_LOAD_C, OP_LDST}, 32'd9, 32'h0BADF00D);
        wait_idle("after_stale", 100);

        // Response on the final timeout cycle wins over the abort.
        rsp_delay = 15;
        send({F7_LOAD_B, OP_LDST}, 32'd7, 32'hCAFE0001);
        wait_idle("edge_rsp", 100);
        rsp_delay = 14;
        send({7'd0, 3'd5}, 32'h0F0F0F0F, 32'h00FF00FF);
        wait_idle("edge_rsp_m1", 100);
        chk("edge_stale", stale_count, exp_stale);

        // Random traffic with random back-pressure everywhere.
        rsp_delay = -1; host_rand = 1'b1; cr_mode = 2; rr_mode = 2;
        for (int i = 0; i < 80; i++) begin
            sel = int'($urandom_range(0, 19));
            if (sel == 0) fid = {7'($urandom), OP_MATMUL};
            else if (sel == 1) fid = {7'($urandom), 3'($urandom_range(2, 7))};
            else fid = {7'($urandom_range(0, 5)), OP_LDST};
            send(fid, $urandom, $urandom);
        end
        wait_idle("random_drain", 6000);
        host_rand = 1'b0; cr_mode = 0; rr_mode = 0; rsp_delay = 2;
        chk("random_stale", stale_count, exp_stale);

        // Stale counter saturates at 255.
        for (int i = 0; i < 260; i++) inject_stale($urandom);
        chk("stale_sat", stale_count, exp_stale);

        // Reset while waiting for a response with two requests queued.
        for (int i = 0; i < 3; i++) send({7'd0, OP_MATMUL}, 32'(i), 32'd0);
        repeat (6) step();
        chk("pre_reset_busy", busy, 1);
        reset = 1'b1;
        host_q.delete(); cmd_q.delete(); sb_q.delete();
        rsp_pending = 1'b0; exp_stale = 0;
        prev_stall = 1'b0; prev_res_stall = 1'b0;
        drive();
        @(negedge clk);
        check_reset_outputs("rst_mid");
        @(posedge clk);
        #1;
        reset = 1'b0;
        res_valid_seen = 0;
        repeat (40) step();
        chk("no_res_after_reset", res_valid_seen, 0);
        chk("busy_after_reset", busy, 0);
        chk("stale_after_reset", stale_count, exp_stale);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cfu_cmd_initiator.md
CFU_CMD_INITIATOR -- requirements
Module: cfu_cmd_initiator

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, request-queue entries (power of 2, >=2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096, the maximum number of WAIT_RSP cycles before abort.
REQ-003 SHALL use one clock and an asynchronous, active-high reset (ports clk, reset).
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 req_valid/req_ready  input/output  1/1  request handshake from the host side.
REQ-007 req_function_id, req_inputs_0, req_inputs_1  input  10/32/32  request payload; function_id bits [2:0] are the opcode and bits [9:3] are funct7.
REQ-008 cmd_valid/cmd_ready  output/input  1/1  command handshake to the CFU.
REQ-009 cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1  output  10/32/32  command payload.
REQ-010 rsp_valid/rsp_ready  input/output  1/1  response handshake from the CFU.
REQ-011 rsp_payload_outputs_0  input  32  response data.
REQ-012 res_valid/res_ready  output/input  1/1  result handshake to the host side.
REQ-013 res_data  output  32  result data.
REQ-014 res_timeout  output  1  the result was produced by a timeout abort.
REQ-015 busy  output  1  the FSM is not IDLE, or the FIFO is non-empty.
REQ-016 stale_count  output  8  saturating count of discarded stray responses.

Function
REQ-017 SHALL accept a request when req_valid&&req_ready and push it into the FIFO; req_ready = !full, taken from the registered count, so a full FIFO refuses even in a pop cycle.
REQ-018 SHALL implement an FSM with states IDLE, ISSUE, WAIT_RSP and DELIVER; exactly one command is outstanding at a time.
REQ-019 IDLE with a non-empty FIFO SHALL pop the head into the registered cmd payload and go to ISSUE; with an empty FIFO it SHALL stay in IDLE.
REQ-020 ISSUE SHALL drive cmd_valid=1 with a payload stable until cmd_ready; on cmd_valid&&cmd_ready it SHALL go to WAIT_RSP.
REQ-021 With an idle FSM and an empty FIFO, a request accepted in cycle n SHALL produce cmd_valid in cycle n+2.
REQ-022 rsp_ready SHALL be 1 in WAIT_RSP and IDLE, and 0 in ISSUE and DELIVER.
REQ-023 In WAIT_RSP, rsp_valid SHALL capture rsp_payload_outputs_0 into res_data, clear res_timeout, and go to DELIVER; res_valid SHALL rise the next cycle.
REQ-024 The WAIT_RSP cycle counter SHALL be cleared on entry to WAIT_RSP.
REQ-025 When the counter reaches TIMEOUT_CYCLES-1 with no rsp_valid, the block SHALL go to DELIVER with res_data=0 and res_timeout=1.
REQ-026 If rsp_valid arrives on the timeout cycle, the response SHALL win: normal result, no timeout.
REQ-027 DELIVER SHALL hold res_valid=1 and a stable res_data/res_timeout until res_ready, then go to IDLE.
REQ-028 rsp_valid in IDLE is a stale response: it SHALL be discarded (handshake completes) and stale_count incremented, saturating at 255.
REQ-029 A push and a pop in the same cycle SHALL leave the count unchanged; FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-030 Results SHALL be returned in request order.

Reset
REQ-031 On reset the block SHALL set: FSM=IDLE; FIFO empty; req_ready=1; cmd_valid=0 and cmd payload=0; rsp_ready=1; res_valid=0, res_data=0, res_timeout=0; busy=0; stale_count=0; timeout counter=0.
REQ-032 Reset mid-operation SHALL drop all queued and outstanding commands, with no result delivered for them.

Structure
REQ-033 Package cfu_pkg SHALL hold the FSM state enum, the opcode and funct7 field widths and positions, and the funct7 constants (LOAD_A=0, LOAD_B=1, LOAD_C=2, STORE_A=3, STORE_B=4, STORE_C=5) and opcode constants (LDST=0, MATMUL=1).
REQ-034 Sub-module cfu_req_fifo (synchronous FIFO of width 74 = 10+32+32 bits, depth FIFO_DEPTH) SHALL be instantiated once.

Verification
REQ-035 Single store, function_id={7'd3,3'd0}, in0=5, in1=0xDEADBEEF; CFU model takes cmd_ready 1 cycle and responds after 2 cycles with 0 -> cmd seen in cycle n+2 with exact payload; res_valid with res_data=0 and res_timeout=0.
REQ-036 Load C, function_id={7'd2,3'd0}, in0=6; model returns 0x12345678 -> res_data=0x12345678.
REQ-037 Push 5 requests back-to-back with res_ready=0 and cmd_ready held 0 -> req_ready falls after 4 accepts; the 5th request is held; after release, all 5 results are delivered in order.
REQ-038 MATMUL, opcode=1; model never responds; TIMEOUT_CYCLES=16 -> res_valid after 16 WAIT_RSP cycles with res_timeout=1 and res_data=0.
REQ-039 Timeout, then the model asserts a late rsp_valid while IDLE -> response consumed and stale_count=1; the next request completes normally.
REQ-040 Assert reset during WAIT_RSP with 2 entries queued -> all outputs at reset values next cycle, busy=0, no res_valid afterwards.
